// File: rtl/mips_pkg.sv
// Shared pipeline types: memory-stage FSM states and memory-op encoding.
package mips_pkg;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    typedef enum logic [1:0] {
        NONE,
        LOAD,
        STORE
    } op_t;

endpackage

// File: rtl/mem_stage.sv
// Memory pipeline stage: passes ALU results straight to writeback, or runs
// one load/store against data memory and holds off upstream until the ack.
import mips_pkg::*;

module mem_stage #(
    parameter int unsigned ALIGN_CHECK = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    output logic        ready_in,
    input  logic [31:0] result,
    input  logic [31:0] rt,
    input  logic [4:0]  dest,
    input  logic        reg_write,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_dest,
    output logic        wb_reg_write,
    output logic        err
);

    state_t      state;
    state_t      state_next;
    op_t         op_q;
    logic [4:0]  dest_q;
    logic        reg_write_q;
    logic        is_mem;
    logic        illegal;

    assign ready_in = (state == IDLE);

    // Decode the incoming op and compute the next FSM state.
    always_comb begin
        is_mem     = mem_read | mem_write;
        illegal    = (mem_read && mem_write) ||
                     (is_mem && (ALIGN_CHECK != 0) && (result[1:0] != 2'b00));
        state_next = state;
        case (state)
            IDLE:    if (valid_in && is_mem && !illegal) state_next = ACCESS;
            ACCESS:  if (mem_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Registered memory interface, op latches and writeback outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_dest      <= '0;
            wb_reg_write <= 1'b0;
            err          <= 1'b0;
            op_q         <= NONE;
            dest_q       <= '0;
            reg_write_q  <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        if (!is_mem) begin
                            wb_valid     <= 1'b1;
                            wb_data      <= result;
                            wb_dest      <= dest;
                            wb_reg_write <= reg_write;
                        end else if (illegal) begin
                            // Rejected op: flag it, never write the register file.
                            wb_valid     <= 1'b1;
                            err          <= 1'b1;
                            wb_reg_write <= 1'b0;
                        end else begin
                            mem_req     <= 1'b1;
                            mem_we      <= mem_write;
                            mem_addr    <= result;
                            mem_wdata   <= rt;
                            dest_q      <= dest;
                            reg_write_q <= reg_write;
                            op_q        <= mem_write ? STORE : LOAD;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_dest  <= dest_q;
                        if (op_q == LOAD) begin
                            wb_data      <= mem_rdata;
                            wb_reg_write <= reg_write_q;
                        end else begin
                            wb_reg_write <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// instruction streams checked against a transaction-level model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [31:0] result;
    logic [31:0] rt;
    logic [4:0]  dest;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        ready_in, mem_req, mem_we, wb_valid, wb_reg_write, err;
    logic [31:0] mem_addr, mem_wdata, wb_data;
    logic [4:0]  wb_dest;

    logic        nc_ready_in, nc_mem_req, nc_mem_we, nc_wb_valid, nc_wb_reg_write, nc_err;
    logic [31:0] nc_mem_addr, nc_mem_wdata, nc_wb_data;
    logic [4:0]  nc_wb_dest;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Model of what the writeback outputs should currently hold.
    logic [31:0] exp_wb_data;
    logic [4:0]  exp_wb_dest;
    logic        data_known;
    logic        dest_known;

    always #5 clk = ~clk;

    mem_stage #(.ALIGN_CHECK(1)) u_dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in),
        .result(result), .rt(rt), .dest(dest), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_dest(wb_dest),
        .wb_reg_write(wb_reg_write), .err(err)
    );

    mem_stage #(.ALIGN_CHECK(0)) u_dut_noalign (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(nc_ready_in),
        .result(result), .rt(rt), .dest(dest), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_req(nc_mem_req), .mem_we(nc_mem_we), .mem_addr(nc_mem_addr), .mem_wdata(nc_mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(nc_wb_valid), .wb_data(nc_wb_data), .wb_dest(nc_wb_dest),
        .wb_reg_write(nc_wb_reg_write), .err(nc_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Checks that the writeback pulse has ended and the held values persist.
    task automatic check_quiet(input string tag);
        check({tag, "_wb_valid_low"}, 32'(wb_valid), 32'd0);
        check({tag, "_err_low"}, 32'(err), 32'd0);
        if (data_known) check({tag, "_wb_data_hold"}, wb_data, exp_wb_data);
        if (dest_known) check({tag, "_wb_dest_hold"}, 32'(wb_dest), 32'(exp_wb_dest));
    endtask

    // Presents one instruction in IDLE and follows it through to writeback.
    // waits = ack-low cycles before the ack; junk instructions are presented
    // while the stage is stalled and must be ignored.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] res,
                         input logic [31:0] st, input logic [4:0] d, input logic rw,
                         input int unsigned waits, input logic [31:0] rdat);
        logic is_mem;
        logic illegal;
        is_mem  = rd | wr;
        illegal = (rd && wr) || (is_mem && (res[1:0] != 2'b00));
        check("accept_ready", 32'(ready_in), 32'd1);
        valid_in = 1'b1; mem_read = rd; mem_write = wr;
        result = res; rt = st; dest = d; reg_write = rw;
        step();
        if (!is_mem || illegal) begin
            valid_in = 1'b0;
            check("wb_valid", 32'(wb_valid), 32'd1);
            check("err", 32'(err), 32'(illegal));
            check("mem_req_none", 32'(mem_req), 32'd0);
            check("ready_after", 32'(ready_in), 32'd1);
            if (!is_mem) begin
                check("alu_wb_data", wb_data, res);
                check("alu_wb_dest", 32'(wb_dest), 32'(d));
                check("alu_wb_reg_write", 32'(wb_reg_write), 32'(rw));
                exp_wb_data = res; exp_wb_dest = d;
                data_known = 1'b1; dest_known = 1'b1;
            end else begin
                check("err_wb_reg_write", 32'(wb_reg_write), 32'd0);
                data_known = 1'b0; dest_known = 1'b0;
            end
        end else begin
            valid_in  = 1'($urandom_range(0, 1));
            result    = $urandom;
            mem_read  = 1'($urandom);
            mem_write = 1'($urandom);
            dest      = 5'($urandom);
            for (int unsigned c = 0; c <= waits; c++) begin
                check("acc_mem_req", 32'(mem_req), 32'd1);
                check("acc_mem_we", 32'(mem_we), 32'(wr));
                check("acc_mem_addr", mem_addr, res);
                check("acc_mem_wdata", mem_wdata, st);
                check("acc_ready", 32'(ready_in), 32'd0);
                check("acc_wb_valid", 32'(wb_valid), 32'd0);
                mem_ack   = (c == waits);
                mem_rdata = (c == waits) ? rdat : $urandom;
                step();
            end
            mem_ack  = 1'b0;
            valid_in = 1'b0;
            check("done_wb_valid", 32'(wb_valid), 32'd1);
            check("done_err", 32'(err), 32'd0);
            check("done_mem_req", 32'(mem_req), 32'd0);
            check("done_ready", 32'(ready_in), 32'd1);
            if (rd) begin
                check("load_wb_data", wb_data, rdat);
                check("load_wb_dest", 32'(wb_dest), 32'(d));
                check("load_wb_reg_write", 32'(wb_reg_write), 32'(rw));
                exp_wb_data = rdat; exp_wb_dest = d;
                data_known = 1'b1; dest_known = 1'b1;
            end else begin
                check("store_wb_reg_write", 32'(wb_reg_write), 32'd0);
                data_known = 1'b0; dest_known = 1'b0;
            end
        end
        mem_read = 1'b0; mem_write = 1'b0;
        step();
        check_quiet("pulse_end");
        check("pulse_end_mem_req", 32'(mem_req), 32'd0);
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; result = '0; rt = '0; dest = '0;
        reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        data_known = 1'b1; dest_known = 1'b1; exp_wb_data = '0; exp_wb_dest = '0;

        // Reset state
        step(); step();
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_dest", 32'(wb_dest), 32'd0);
        rst = 1'b0;
        step();
        check("ready_after_rst", 32'(ready_in), 32'd1);

        // ALU pass-through, zero-wait load, wait-state store
        issue(1'b0, 1'b0, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 0, 32'h0);
        issue(1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd3, 1'b1, 0, 32'hDEAD_BEEF);
        issue(1'b0, 1'b1, 32'h0000_0200, 32'hCAFE_F00D, 5'd4, 1'b1, 3, 32'h0);
        // Misaligned load and read+write both high
        issue(1'b1, 1'b0, 32'h0000_0102, 32'h0, 5'd6, 1'b1, 0, 32'h0);
        issue(1'b1, 1'b1, 32'h0000_0040, 32'h0, 5'd6, 1'b1, 0, 32'h0);

        // Reset in the second ACCESS cycle, then a late ack
        valid_in = 1'b1; mem_read = 1'b1; result = 32'h0000_0400; dest = 5'd8; reg_write = 1'b1;
        step();
        valid_in = 1'b0; mem_read = 1'b0;
        step();
        check("rst_acc_mem_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
        check("rst_acc_req_drop", 32'(mem_req), 32'd0);
        check("rst_acc_no_wb", 32'(wb_valid), 32'd0);
        check("rst_acc_ready", 32'(ready_in), 32'd1);
        step();
        mem_ack = 1'b0;
        exp_wb_data = '0; exp_wb_dest = '0; data_known = 1'b1; dest_known = 1'b1;
        check_quiet("late_ack");
        check("late_ack_mem_req", 32'(mem_req), 32'd0);

        // Back-to-back: ALU op waits behind a stalled load
        valid_in = 1'b1; mem_read = 1'b1; result = 32'h0000_0300; dest = 5'd7; reg_write = 1'b1;
        step();
        result = 32'h0000_5555; dest = 5'd9; mem_read = 1'b0; reg_write = 1'b1;
        for (int unsigned c = 0; c < 3; c++) begin
            check("b2b_ready", 32'(ready_in), 32'd0);
            check("b2b_wb_valid", 32'(wb_valid), 32'd0);
            check("b2b_mem_addr", mem_addr, 32'h0000_0300);
            mem_ack = (c == 2); mem_rdata = 32'h1111_2222;
            step();
        end
        mem_ack = 1'b0;
        check("b2b_load_valid", 32'(wb_valid), 32'd1);
        check("b2b_load_data", wb_data, 32'h1111_2222);
        check("b2b_load_dest", 32'(wb_dest), 32'd7);
        step();
        valid_in = 1'b0;
        check("b2b_alu_valid", 32'(wb_valid), 32'd1);
        check("b2b_alu_data", wb_data, 32'h0000_5555);
        check("b2b_alu_dest", 32'(wb_dest), 32'd9);
        check("b2b_alu_mem_req", 32'(mem_req), 32'd0);
        exp_wb_data = 32'h0000_5555; exp_wb_dest = 5'd9;
        step();
        check_quiet("b2b_end");

        // Randomized instruction stream with spurious acks while idle
        for (int i = 0; i < 150; i++) begin
            int unsigned k;
            logic [31:0] res;
            k   = $urandom_range(0, 9);
            res = $urandom;
            if ($urandom_range(0, 3) != 0) res[1:0] = 2'b00;
            issue((k >= 4 && k <= 6) || k == 9, k >= 7, res, $urandom, 5'($urandom),
                  1'($urandom), $urandom_range(0, 4), $urandom);
            if ($urandom_range(0, 2) == 0) begin
                mem_ack = 1'b1; mem_rdata = $urandom;
                step();
                mem_ack = 1'b0;
                check_quiet("idle_ack");
                check("idle_ack_mem_req", 32'(mem_req), 32'd0);
                check("idle_ack_ready", 32'(ready_in), 32'd1);
            end
        end

        // Misaligned load against both alignment settings
        rst = 1'b1;
        step();
        rst = 1'b0;
        valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
        result = 32'h0000_0102; rt = '0; dest = 5'd2; reg_write = 1'b1;
        step();
        valid_in = 1'b0; mem_read = 1'b0;
        check("mis_err", 32'(err), 32'd1);
        check("mis_wb_valid", 32'(wb_valid), 32'd1);
        check("mis_mem_req", 32'(mem_req), 32'd0);
        check("noalign_mem_req", 32'(nc_mem_req), 32'd1);
        check("noalign_mem_addr", nc_mem_addr, 32'h0000_0102);
        check("noalign_err", 32'(nc_err), 32'd0);
        check("noalign_ready", 32'(nc_ready_in), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hA5A5_5A5A;
        step();
        mem_ack = 1'b0;
        check("noalign_wb_valid", 32'(nc_wb_valid), 32'd1);
        check("noalign_wb_data", nc_wb_data, 32'hA5A5_5A5A);
        check("noalign_wb_dest", 32'(nc_wb_dest), 32'd2);
        check("mis_ack_ignored", 32'(wb_valid), 32'd0);
        check("mis_err_pulse", 32'(err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
